pattern_det_arb: RTL and testbench
==================================

PATTERN_DET_ARB -- requirements
Module: pattern_det_arb

Interface
REQ-001: Parameter CNT_W, default 8, sets the width of each per-requester match counter.
REQ-002: Parameter MAX_BEATS, default 1023, sets the maximum valid beats per grant before forced release.
REQ-003: clk  input  1  single clock; all state changes on its rising edge.
REQ-004: rst  input  1  reset, asynchronous, active-high.
REQ-005: req_i  input  2  per-requester request; bit n belongs to requester n.
REQ-006: data_i  input  2  per-requester serial data bit.
REQ-007: valid_i  input  2  per-requester data-valid qualifier.
REQ-008: last_i  input  2  per-requester end-of-stream marker, qualified by valid_i.
REQ-009: clr_i  input  1  synchronous clear of both match counters.
REQ-010: det_pattern_i  input  1  match pulse returned by the shared pattern detector.
REQ-011: gnt_o  output  2  one-hot grant; at most one bit set.
REQ-012: det_rst_o  output  1  flush/reset to the shared detector.
REQ-013: det_data_o  output  1  serial bit forwarded to the detector.
REQ-014: det_valid_o  output  1  valid forwarded to the detector.
REQ-015: match_cnt0_o  output  CNT_W  match count for requester 0.
REQ-016: match_cnt1_o  output  CNT_W  match count for requester 1.
REQ-017: busy_o  output  1  high in any state other than IDLE.

Function
REQ-018: The FSM SHALL have four states: IDLE, FLUSH, GRANT and DRAIN.
REQ-019: IDLE: when any req_i bit is set, the FSM SHALL select the owner by round-robin pointer rr and go to FLUSH; otherwise it stays in IDLE.
REQ-020: Round-robin rule: if both requests are set, the owner is rr; if one is set, that requester is the owner.
REQ-021: FLUSH SHALL last exactly 1 cycle with det_rst_o=1 and gnt_o=0, then go to GRANT.
REQ-022: GRANT: gnt_o SHALL equal the owner one-hot; det_data_o=data_i[owner] and det_valid_o=valid_i[owner], combinationally.
REQ-023: Outside GRANT, det_valid_o=0 and det_data_o=0.
REQ-024: GRANT SHALL count owner valid beats; on valid_i[owner]&last_i[owner], or when the beat count reaches MAX_BEATS, the FSM SHALL go to DRAIN.
REQ-025: In GRANT, deassertion of req_i[owner] without last SHALL also go to DRAIN (abort).
REQ-026: DRAIN SHALL last 1 cycle with gnt_o=0 and det_valid_o=0, to capture a late detector match.
REQ-027: On DRAIN exit, rr SHALL become the non-owner.
REQ-028: On DRAIN exit, the FSM SHALL go to FLUSH if any req_i is set (back-to-back, no IDLE cycle); otherwise it goes to IDLE.
REQ-029: In GRANT and DRAIN, det_pattern_i=1 SHALL increment the owner's counter by 1 per cycle.
REQ-030: Counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-031: clr_i SHALL zero both counters next cycle and take priority over a simultaneous increment.
REQ-032: det_pattern_i outside GRANT/DRAIN SHALL be ignored.
REQ-033: Requests from the non-owner during GRANT SHALL be held pending and never preempt the current owner.
REQ-034: The beat counter SHALL reset to 0 on entry to GRANT.

Reset
REQ-035: rst SHALL asynchronously force the following: state=IDLE, rr=0, gnt_o=0, det_rst_o=1, det_valid_o=0, det_data_o=0, both counters=0, busy_o=0, beat counter=0.
REQ-036: det_rst_o SHALL be 1 while rst is high and 0 in IDLE after rst release.
REQ-037: rst asserted mid-GRANT SHALL abort immediately; no counter update SHALL occur on that cycle.

Verification
REQ-038: Scenario: req_i=01, stream 1,1,0,1,0 with last on the 5th beat, det_pattern_i pulsed on beat 5 -> FLUSH for 1 cycle, gnt_o=01 for 5 cycles, match_cnt0_o=1, match_cnt1_o=0, busy_o low 2 cycles after last.
REQ-039: Scenario: req_i=11 held, each stream 4 beats -> grant order 01,10,01; each grant preceded by exactly 1 FLUSH cycle; never both grant bits set.
REQ-040: Scenario: det_pattern_i pulsed in the DRAIN cycle of requester 1 -> match_cnt1_o increments by 1.
REQ-041: Scenario: CNT_W=8, 300 match pulses for requester 0 -> match_cnt0_o=255; then clr_i for 1 cycle -> 0.
REQ-042: Scenario: MAX_BEATS=8, last_i never asserted -> DRAIN after the 8th valid beat, then grant passes to the other pending requester.
REQ-043: Scenario: rst pulsed during GRANT -> gnt_o=0 and counters=0 immediately; on rst release, re-arbitration starts with requester 0.

Source files
------------

// File: rtl/pattern_det_arb.sv
// Two-requester round-robin arbiter that time-shares one serial pattern detector
// and keeps a saturating match count per requester.
module pattern_det_arb #(
   parameter int CNT_W     = 8,
   parameter int MAX_BEATS = 1023
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       req_i,
   input  logic [1:0]       data_i,
   input  logic [1:0]       valid_i,
   input  logic [1:0]       last_i,
   input  logic             clr_i,
   input  logic             det_pattern_i,
   output logic [1:0]       gnt_o,
   output logic             det_rst_o,
   output logic             det_data_o,
   output logic             det_valid_o,
   output logic [CNT_W-1:0] match_cnt0_o,
   output logic [CNT_W-1:0] match_cnt1_o,
   output logic             busy_o
);

   localparam int BEAT_W = $clog2(MAX_BEATS + 1);
   localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(MAX_BEATS - 1);

   typedef enum logic [1:0] {IDLE, FLUSH, GRANT, DRAIN} state_t;

   state_t            state_q, state_d;
   logic              rr_q, rr_d;
   logic              owner_q, owner_d;
   logic [BEAT_W-1:0] beat_q, beat_d;
   logic [CNT_W-1:0]  cnt0_q, cnt0_d;
   logic [CNT_W-1:0]  cnt1_q, cnt1_d;

   // With both requesting, the pointer decides; otherwise the lone requester wins.
   function automatic logic pick(input logic [1:0] req, input logic rr);
      pick = (req == 2'b11) ? rr : req[1];
   endfunction

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      state_d = state_q;
      rr_d    = rr_q;
      owner_d = owner_q;
      beat_d  = beat_q;
      case (state_q)
         IDLE: begin
            if (|req_i) begin
               owner_d = pick(req_i, rr_q);
               state_d = FLUSH;
            end
         end
         FLUSH: begin
            beat_d  = '0;
            state_d = GRANT;
         end
         GRANT: begin
            if (valid_i[owner_q]) beat_d = beat_q + BEAT_W'(1);
            if (!req_i[owner_q])
               state_d = DRAIN;
            else if (valid_i[owner_q] && (last_i[owner_q] || beat_q == BEAT_LAST))
               state_d = DRAIN;
         end
         DRAIN: begin
            rr_d = ~owner_q;
            if (|req_i) begin
               owner_d = pick(req_i, ~owner_q);
               state_d = FLUSH;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Matches are credited during GRANT and the following DRAIN cycle only.
   always_comb begin
      cnt0_d = cnt0_q;
      cnt1_d = cnt1_q;
      if (clr_i) begin
         cnt0_d = '0;
         cnt1_d = '0;
      end else if (det_pattern_i && (state_q == GRANT || state_q == DRAIN)) begin
         if (!owner_q) begin
            if (cnt0_q != '1) cnt0_d = cnt0_q + CNT_W'(1);
         end else begin
            if (cnt1_q != '1) cnt1_d = cnt1_q + CNT_W'(1);
         end
      end
   end

   always_comb begin
      gnt_o       = '0;
      det_data_o  = 1'b0;
      det_valid_o = 1'b0;
      if (state_q == GRANT) begin
         gnt_o[owner_q] = 1'b1;
         det_data_o     = data_i[owner_q];
         det_valid_o    = valid_i[owner_q];
      end
   end

   // The detector is held in reset while rst is high, not only during FLUSH.
   assign det_rst_o    = rst | (state_q == FLUSH);
   assign busy_o       = (state_q != IDLE);
   assign match_cnt0_o = cnt0_q;
   assign match_cnt1_o = cnt1_q;

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         rr_q    <= 1'b0;
         owner_q <= 1'b0;
         beat_q  <= '0;
         cnt0_q  <= '0;
         cnt1_q  <= '0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         owner_q <= owner_d;
         beat_q  <= beat_d;
         cnt0_q  <= cnt0_d;
         cnt1_q  <= cnt1_d;
      end
   end

endmodule

// File: tb/tb_pattern_det_arb.sv
// Directed bench for pattern_det_arb: a vector table for the main streams plus
// hand-written sequences for saturation, beat limit, abort and mid-grant reset.
module tb_pattern_det_arb;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] req_i = '0, data_i = '0, valid_i = '0, last_i = '0;
   logic       clr_i = 1'b0, det_pattern_i = 1'b0;
   logic [1:0] gnt_o;
   logic       det_rst_o, det_data_o, det_valid_o, busy_o;
   logic [7:0] match_cnt0_o, match_cnt1_o;

   int n_cmp = 0;
   int n_bad = 0;

   pattern_det_arb #(.CNT_W(8), .MAX_BEATS(8)) dut (
      .clk           (clk),
      .rst           (rst),
      .req_i         (req_i),
      .data_i        (data_i),
      .valid_i       (valid_i),
      .last_i        (last_i),
      .clr_i         (clr_i),
      .det_pattern_i (det_pattern_i),
      .gnt_o         (gnt_o),
      .det_rst_o     (det_rst_o),
      .det_data_o    (det_data_o),
      .det_valid_o   (det_valid_o),
      .match_cnt0_o  (match_cnt0_o),
      .match_cnt1_o  (match_cnt1_o),
      .busy_o        (busy_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic [1:0] req, data, valid, last;
      logic       clr, det;
      logic [1:0] gnt;
      logic       drst, ddata, dvalid, busy;
      logic [7:0] c0, c1;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic r, input logic [1:0] rq, input logic [1:0] d,
                      input logic [1:0] v, input logic [1:0] l, input logic c,
                      input logic dp, input logic [1:0] g, input logic dr,
                      input logic dd, input logic dv, input logic b,
                      input logic [7:0] e0, input logic [7:0] e1);
      vec_t x;
      x.rst = r; x.req = rq; x.data = d; x.valid = v; x.last = l; x.clr = c; x.det = dp;
      x.gnt = g; x.drst = dr; x.ddata = dd; x.dvalid = dv; x.busy = b; x.c0 = e0; x.c1 = e1;
      tbl.push_back(x);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Inputs change on the falling edge; outputs are sampled 1 ns before the rising edge.
   task automatic cyc(input logic r, input logic [1:0] rq, input logic [1:0] d,
                      input logic [1:0] v, input logic [1:0] l, input logic c, input logic dp);
      @(negedge clk);
      rst = r; req_i = rq; data_i = d; valid_i = v; last_i = l; clr_i = c; det_pattern_i = dp;
      #4;
   endtask

   initial begin
      // rst req data valid last clr det | gnt drst ddata dvalid busy c0 c1
      // Single stream on requester 0: bits 1,1,0,1,0, match on beat 5.
      add(1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 1, 0, 0, 0, 0, 0);
      add(0, 2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
      add(0, 2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 1, 0, 0, 1, 0, 0);
      add(0, 2'b01, 2'b01, 2'b01, 2'b00, 0, 0, 2'b01, 0, 1, 1, 1, 0, 0);
      add(0, 2'b01, 2'b01, 2'b01, 2'b00, 0, 0, 2'b01, 0, 1, 1, 1, 0, 0);
      add(0, 2'b01, 2'b10, 2'b01, 2'b00, 0, 0, 2'b01, 0, 0, 1, 1, 0, 0);
      add(0, 2'b01, 2'b01, 2'b01, 2'b00, 0, 0, 2'b01, 0, 1, 1, 1, 0, 0);
      add(0, 2'b01, 2'b10, 2'b01, 2'b01, 0, 1, 2'b01, 0, 0, 1, 1, 0, 0);
      add(0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 0, 0, 0, 1, 1, 0);
      add(0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 1, 0);
      // Both requesting, 4-beat streams: grants 01, 10, 01; matches in IDLE/FLUSH ignored,
      // match in requester 1's DRAIN credited.
      add(1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 1, 0, 0, 0, 0, 0);
      add(0, 2'b11, 2'b00, 2'b00, 2'b00, 0, 1, 2'b00, 0, 0, 0, 0, 0, 0);
      add(0, 2'b11, 2'b00, 2'b00, 2'b00, 0, 1, 2'b00, 1, 0, 0, 1, 0, 0);
      add(0, 2'b11, 2'b01, 2'b11, 2'b00, 0, 0, 2'b01, 0, 1, 1, 1, 0, 0);
      add(0, 2'b11, 2'b10, 2'b11, 2'b00, 0, 0, 2'b01, 0, 0, 1, 1, 0, 0);
      add(0, 2'b11, 2'b11, 2'b11, 2'b00, 0, 0, 2'b01, 0, 1, 1, 1, 0, 0);
      add(0, 2'b11, 2'b00, 2'b11, 2'b11, 0, 0, 2'b01, 0, 0, 1, 1, 0, 0);
      add(0, 2'b11, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 0, 0, 0, 1, 0, 0);
      add(0, 2'b11, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 1, 0, 0, 1, 0, 0);
      add(0, 2'b11, 2'b01, 2'b11, 2'b00, 0, 0, 2'b10, 0, 0, 1, 1, 0, 0);
      add(0, 2'b11, 2'b10, 2'b11, 2'b00, 0, 0, 2'b10, 0, 1, 1, 1, 0, 0);
      add(0, 2'b11, 2'b11, 2'b11, 2'b00, 0, 0, 2'b10, 0, 1, 1, 1, 0, 0);
      add(0, 2'b11, 2'b00, 2'b11, 2'b11, 0, 0, 2'b10, 0, 0, 1, 1, 0, 0);
      add(0, 2'b11, 2'b00, 2'b00, 2'b00, 0, 1, 2'b00, 0, 0, 0, 1, 0, 0);
      add(0, 2'b11, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 1, 0, 0, 1, 0, 1);
      add(0, 2'b11, 2'b01, 2'b11, 2'b00, 0, 0, 2'b01, 0, 1, 1, 1, 0, 1);
      add(0, 2'b11, 2'b10, 2'b11, 2'b00, 0, 0, 2'b01, 0, 0, 1, 1, 0, 1);
      add(0, 2'b11, 2'b11, 2'b11, 2'b00, 0, 0, 2'b01, 0, 1, 1, 1, 0, 1);
      add(0, 2'b11, 2'b00, 2'b11, 2'b11, 0, 0, 2'b01, 0, 0, 1, 1, 0, 1);
      add(0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 0, 0, 0, 1, 0, 1);
      add(0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1);

      for (int i = 0; i < tbl.size(); i++) begin
         cyc(tbl[i].rst, tbl[i].req, tbl[i].data, tbl[i].valid, tbl[i].last,
             tbl[i].clr, tbl[i].det);
         check($sformatf("row%0d gnt", i), 32'(gnt_o), 32'(tbl[i].gnt));
         check($sformatf("row%0d det_rst", i), 32'(det_rst_o), 32'(tbl[i].drst));
         check($sformatf("row%0d det_data", i), 32'(det_data_o), 32'(tbl[i].ddata));
         check($sformatf("row%0d det_valid", i), 32'(det_valid_o), 32'(tbl[i].dvalid));
         check($sformatf("row%0d busy", i), 32'(busy_o), 32'(tbl[i].busy));
         check($sformatf("row%0d cnt0", i), 32'(match_cnt0_o), 32'(tbl[i].c0));
         check($sformatf("row%0d cnt1", i), 32'(match_cnt1_o), 32'(tbl[i].c1));
      end

      // Saturation: 300 matches while requester 0 holds the grant without beats.
      cyc(1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
      cyc(0, 2'b01, 2'b00, 2'b00, 2'b00, 0, 0);
      cyc(0, 2'b01, 2'b00, 2'b00, 2'b00, 0, 0);
      for (int i = 0; i < 300; i++) cyc(0, 2'b01, 2'b00, 2'b00, 2'b00, 0, 1);
      cyc(0, 2'b01, 2'b00, 2'b00, 2'b00, 0, 0);
      check("sat cnt0", 32'(match_cnt0_o), 32'd255);
      check("sat cnt1", 32'(match_cnt1_o), 32'd0);
      check("sat gnt held", 32'(gnt_o), 32'(2'b01));
      cyc(0, 2'b01, 2'b00, 2'b00, 2'b00, 1, 1);
      cyc(0, 2'b01, 2'b00, 2'b00, 2'b00, 0, 0);
      check("clr cnt0", 32'(match_cnt0_o), 32'd0);

      // Beat limit: no last; requester 0 released after 8 valid beats, then requester 1.
      cyc(1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
      for (int k = 0; k <= 12; k++) begin
         logic [1:0] eg;
         cyc(0, 2'b11, 2'b11, 2'b11, 2'b00, 0, 0);
         eg = (k < 2) ? 2'b00 : (k < 10) ? 2'b01 : (k < 12) ? 2'b00 : 2'b10;
         check($sformatf("maxbeat k%0d gnt", k), 32'(gnt_o), 32'(eg));
      end

      // Abort: owner drops its request mid-stream, DRAIN then IDLE.
      cyc(1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
      cyc(0, 2'b01, 2'b00, 2'b00, 2'b00, 0, 0);
      cyc(0, 2'b01, 2'b00, 2'b00, 2'b00, 0, 0);
      cyc(0, 2'b01, 2'b01, 2'b01, 2'b00, 0, 0);
      check("abort gnt", 32'(gnt_o), 32'(2'b01));
      cyc(0, 2'b00, 2'b01, 2'b01, 2'b00, 0, 0);
      cyc(0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
      check("abort drain gnt", 32'(gnt_o), 32'(2'b00));
      check("abort drain busy", 32'(busy_o), 32'd1);
      cyc(0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
      check("abort idle busy", 32'(busy_o), 32'd0);

      // Reset in the middle of requester 1's grant.
      cyc(1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
      cyc(0, 2'b11, 2'b00, 2'b00, 2'b00, 0, 0);
      cyc(0, 2'b11, 2'b00, 2'b00, 2'b00, 0, 0);
      cyc(0, 2'b11, 2'b00, 2'b01, 2'b01, 0, 1);
      cyc(0, 2'b11, 2'b00, 2'b00, 2'b00, 0, 0);
      cyc(0, 2'b11, 2'b00, 2'b00, 2'b00, 0, 0);
      cyc(0, 2'b11, 2'b00, 2'b00, 2'b00, 0, 1);
      check("pre-rst gnt", 32'(gnt_o), 32'(2'b10));
      cyc(0, 2'b11, 2'b00, 2'b00, 2'b00, 0, 1);
      check("pre-rst cnt0", 32'(match_cnt0_o), 32'd1);
      check("pre-rst cnt1", 32'(match_cnt1_o), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("rst gnt", 32'(gnt_o), 32'(2'b00));
      check("rst cnt0", 32'(match_cnt0_o), 32'd0);
      check("rst cnt1", 32'(match_cnt1_o), 32'd0);
      check("rst busy", 32'(busy_o), 32'd0);
      check("rst det_rst", 32'(det_rst_o), 32'd1);
      cyc(0, 2'b11, 2'b00, 2'b00, 2'b00, 0, 0);
      check("post-rst det_rst", 32'(det_rst_o), 32'd0);
      cyc(0, 2'b11, 2'b00, 2'b00, 2'b00, 0, 0);
      cyc(0, 2'b11, 2'b00, 2'b00, 2'b00, 0, 0);
      check("post-rst first gnt", 32'(gnt_o), 32'(2'b01));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // One-hot grant must hold on every sampled cycle.
   always @(negedge clk) begin
      if (gnt_o == 2'b11) begin
         n_cmp++;
         n_bad++;
         $display("FAIL onehot gnt: got %0b expected at most one bit", gnt_o);
      end
   end

endmodule
